// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the hazard scoreboard.
//   PC_*   : encodings of the sel_PC next-PC select.
//   FWD_*  : encodings of the sel_A / sel_B forwarding selects.
//   lop_state_t : state of the single-entry long-op scoreboard.
package hazard_pkg;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_JR     = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lop_state_t;

endpackage

// File: rtl/hazard_scoreboard_lop_tracker.sv
// lop_tracker: tracks one outstanding long-latency GPR-writing operation.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   issue        : long op leaves ID this cycle (captured at the next edge)
//   rd_in        : destination register of the issuing op
//   state        : scoreboard state (BUSY == entry valid)
//   lop_done     : one-cycle pulse in the writeback cycle (issue edge + LOP_LATENCY)
//   lop_rd       : destination of the outstanding op
module lop_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int LOP_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic [REG_AW-1:0] rd_in,
    output lop_state_t        state,
    output logic              lop_done,
    output logic [REG_AW-1:0] lop_rd
);

    localparam int CW = $clog2(LOP_LATENCY + 1);

    lop_state_t        state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [REG_AW-1:0] rd_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            lop_rd <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            lop_rd <= rd_next;
        end
    end

    // The counter is loaded with LOP_LATENCY-1 so that cnt reaches 0 exactly
    // in the writeback cycle; the entry stays valid through that cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rd_next    = lop_rd;
        lop_done   = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = BUSY;
                    cnt_next   = CW'(LOP_LATENCY - 1);
                    rd_next    = rd_in;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    lop_done   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding, load-use stall, branch/jump flush and a
// single-entry long-op scoreboard for the ID/EX stages.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cnt / flush_cnt.
// Ports:
//   sel_PC             : 00 next, 01 jump, 10 JR, 11 branch taken
//   lw_EX, rd_EX       : load in EX and its destination
//   rs1_ID, rs2_ID, rd_ID, lop_ID : ID operands / long-op flag
//   rs1_EX, rs2_EX     : EX sources for forwarding
//   rd_MEM/WB, reg_wr_MEM/WB : later-stage writers
//   stall, flush_ID, flush_EX : pipeline control
//   sel_A, sel_B       : forward selects (00 reg, 01 MEM, 10 WB)
//   lop_busy, lop_done, lop_rd : scoreboard status
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int LOP_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel_PC,
    input  logic              lw_EX,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic              lop_ID,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic [REG_AW-1:0] rs1_EX,
    input  logic [REG_AW-1:0] rs2_EX,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic [REG_AW-1:0] rd_WB,
    input  logic              reg_wr_MEM,
    input  logic              reg_wr_WB,
    output logic              stall,
    output logic              flush_ID,
    output logic              flush_EX,
    output logic [1:0]        sel_A,
    output logic [1:0]        sel_B,
    output logic              lop_busy,
    output logic              lop_done,
    output logic [REG_AW-1:0] lop_rd
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    lop_state_t lop_state;
    logic       load_stall;
    logic       sb_stall;
    logic       struct_stall;
    logic       issue;

    // MEM has priority over WB: it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (rs != '0 && reg_wr_MEM && rs == rd_MEM)
            return FWD_MEM;
        else if (rs != '0 && reg_wr_WB && rs == rd_WB)
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    always_comb begin
        sel_A = fwd_sel(rs1_EX);
        sel_B = fwd_sel(rs2_EX);
    end

    assign load_stall   = lw_EX && (rd_EX != '0) &&
                          ((rs1_ID == rd_EX) || (rs2_ID == rd_EX));
    // Matching rd_ID as well blocks WAW against the outstanding long op.
    assign sb_stall     = lop_busy && (lop_rd != '0) &&
                          ((rs1_ID == lop_rd) || (rs2_ID == lop_rd) || (rd_ID == lop_rd));
    assign struct_stall = lop_ID && lop_busy;
    assign stall        = load_stall || sb_stall || struct_stall;

    assign flush_ID = (sel_PC != PC_NEXT);
    assign flush_EX = stall || sel_PC[1];

    // A long op killed by a taken branch or JR never enters the scoreboard.
    assign issue = lop_ID && !stall && !sel_PC[1];

    lop_tracker #(
        .REG_AW      (REG_AW),
        .LOP_LATENCY (LOP_LATENCY)
    ) u_lop_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (issue),
        .rd_in    (rd_ID),
        .state    (lop_state),
        .lop_done (lop_done),
        .lop_rd   (lop_rd)
    );

    assign lop_busy = (lop_state == BUSY);

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_ID && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard
// with default parameters (REG_AW=5, LOP_LATENCY=4).
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic [1:0] sel_PC;
    logic       lw_EX;
    logic [4:0] rs1_ID, rs2_ID, rd_ID;
    logic       lop_ID;
    logic [4:0] rd_EX, rs1_EX, rs2_EX, rd_MEM, rd_WB;
    logic       reg_wr_MEM, reg_wr_WB;
    logic       stall, flush_ID, flush_EX;
    logic [1:0] sel_A, sel_B;
    logic       lop_busy, lop_done;
    logic [4:0] lop_rd;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_PC     (sel_PC),
        .lw_EX      (lw_EX),
        .rs1_ID     (rs1_ID),
        .rs2_ID     (rs2_ID),
        .rd_ID      (rd_ID),
        .lop_ID     (lop_ID),
        .rd_EX      (rd_EX),
        .rs1_EX     (rs1_EX),
        .rs2_EX     (rs2_EX),
        .rd_MEM     (rd_MEM),
        .rd_WB      (rd_WB),
        .reg_wr_MEM (reg_wr_MEM),
        .reg_wr_WB  (reg_wr_WB),
        .stall      (stall),
        .flush_ID   (flush_ID),
        .flush_EX   (flush_EX),
        .sel_A      (sel_A),
        .sel_B      (sel_B),
        .lop_busy   (lop_busy),
        .lop_done   (lop_done),
        .lop_rd     (lop_rd)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        sel_PC = 2'b00; lw_EX = 1'b0;
        rs1_ID = '0; rs2_ID = '0; rd_ID = '0; lop_ID = 1'b0;
        rd_EX = '0; rs1_EX = '0; rs2_EX = '0; rd_MEM = '0; rd_WB = '0;
        reg_wr_MEM = 1'b0; reg_wr_WB = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change there.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Wait for the scoreboard to empty, bounded.
    task automatic wait_idle();
        int n = 0;
        while (lop_busy && n < 20) begin
            next_cycle();
            n++;
        end
        check("wait_idle_timeout", {31'd0, lop_busy}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #12;
        // reset state
        check("rst_busy", {31'd0, lop_busy}, 32'd0);
        check("rst_done", {31'd0, lop_done}, 32'd0);
        check("rst_rd",   {27'd0, lop_rd},   32'd0);
        check("rst_stall", {31'd0, stall},   32'd0);
        rst_n = 1'b1;
        next_cycle();

        // ---- forwarding ----
        rs1_EX = 5; rd_MEM = 5; reg_wr_MEM = 1; rd_WB = 5; reg_wr_WB = 1;
        settle();
        check("fwd_a_mem_prio", {30'd0, sel_A}, 32'h1);
        rs1_EX = 0; settle();
        check("fwd_a_zero", {30'd0, sel_A}, 32'h0);
        rs2_EX = 7; rd_MEM = 3; rd_WB = 7; settle();
        check("fwd_b_wb", {30'd0, sel_B}, 32'h2);
        reg_wr_WB = 0; settle();
        check("fwd_b_nowr", {30'd0, sel_B}, 32'h0);
        clear_inputs();

        // ---- load-use ----
        lw_EX = 1; rd_EX = 8; rs2_ID = 8; settle();
        check("lu_stall",    {31'd0, stall},    32'd1);
        check("lu_flush_ex", {31'd0, flush_EX}, 32'd1);
        check("lu_flush_id", {31'd0, flush_ID}, 32'd0);
        rd_EX = 0; rs2_ID = 0; settle();
        check("lu_rd0", {31'd0, stall}, 32'd0);
        clear_inputs();

        // ---- long op, RAW dependent waits through the done cycle ----
        lop_ID = 1; rd_ID = 9; settle();
        check("lop_issue_nostall", {31'd0, stall}, 32'd0);
        next_cycle();
        lop_ID = 0; rd_ID = 0; rs1_ID = 9;
        for (int c = 1; c <= 4; c++) begin
            settle();
            check($sformatf("lop_stall_c%0d", c), {31'd0, stall}, 32'd1);
            check($sformatf("lop_done_c%0d", c), {31'd0, lop_done}, (c == 4) ? 32'd1 : 32'd0);
            check($sformatf("lop_rd_c%0d", c), {27'd0, lop_rd}, 32'd9);
            next_cycle();
        end
        check("lop_c5_stall", {31'd0, stall},    32'd0);
        check("lop_c5_busy",  {31'd0, lop_busy}, 32'd0);
        check("lop_c5_done",  {31'd0, lop_done}, 32'd0);
        clear_inputs();

        // ---- structural / WAW / unrelated ----
        lop_ID = 1; rd_ID = 9; next_cycle();
        lop_ID = 1; rd_ID = 3; settle();
        check("struct_stall", {31'd0, stall}, 32'd1);
        lop_ID = 0; rd_ID = 9; settle();
        check("waw_stall", {31'd0, stall}, 32'd1);
        rd_ID = 3; rs1_ID = 1; rs2_ID = 2; settle();
        check("unrelated_nostall", {31'd0, stall}, 32'd0);
        next_cycle();
        clear_inputs();
        wait_idle();
        next_cycle();

        // ---- rd 0 long op: tracked, never a dependency ----
        lop_ID = 1; rd_ID = 0; next_cycle();
        lop_ID = 0; settle();
        check("rd0_busy", {31'd0, lop_busy}, 32'd1);
        check("rd0_nostall", {31'd0, stall}, 32'd0);
        wait_idle();

        // ---- branch kill ----
        lop_ID = 1; rd_ID = 9; sel_PC = 2'b11; settle();
        check("br_flush_id", {31'd0, flush_ID}, 32'd1);
        check("br_flush_ex", {31'd0, flush_EX}, 32'd1);
        next_cycle();
        clear_inputs(); settle();
        check("br_not_busy", {31'd0, lop_busy}, 32'd0);
        sel_PC = 2'b01; settle();
        check("jump_flush_ex", {31'd0, flush_EX}, 32'd0);
        check("jump_flush_id", {31'd0, flush_ID}, 32'd1);
        clear_inputs();

        // ---- branch does not cancel an issued op ----
        lop_ID = 1; rd_ID = 6; next_cycle();
        lop_ID = 0; sel_PC = 2'b10; next_cycle();
        check("br_keeps_op", {31'd0, lop_busy}, 32'd1);
        clear_inputs();
        wait_idle();

        // ---- reset mid-BUSY ----
        lop_ID = 1; rd_ID = 9; next_cycle();
        lop_ID = 0; next_cycle();   // cycle 2
        rst_n = 1'b0; settle();
        check("rstb_busy", {31'd0, lop_busy}, 32'd0);
        check("rstb_rd",   {27'd0, lop_rd},   32'd0);
        lw_EX = 1; rd_EX = 8; rs1_ID = 8; settle();
        check("rstb_load_stall", {31'd0, stall}, 32'd1);
        rs1_ID = 9; lw_EX = 0; settle();
        check("rstb_no_sb_stall", {31'd0, stall}, 32'd0);
        begin
            int seen = 0;
            for (int c = 0; c < 5; c++) begin
                next_cycle();
                if (lop_done) seen++;
            end
            check("rstb_no_done", seen, 32'd0);
        end
`ifdef HAZARD_PERF_CNT_EN
        check("rstb_stall_cnt", stall_cnt, 32'd0);
        check("rstb_flush_cnt", flush_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        clear_inputs();
        next_cycle();
        check("post_rst_busy", {31'd0, lop_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipelined MIPS32 hazard unit.
- Keeps the combinational forwarding, load-use stall and branch/jump flush logic.
- Adds a sequential single-entry scoreboard for one outstanding long-latency GPR-writing operation (mult/div class) with configurable latency.
- Sits beside the ID/EX pipeline registers and drives stall/flush/forward selects for the datapath.

Parameters:
- REG_AW, 5, register index width (2**REG_AW architectural registers; index 0 is hard-zero).
- LOP_LATENCY, 4, cycles from long-op issue to its result writeback; legal range 2..15.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sel_PC  in  2  00 next, 01 jump, 10 JR, 11 branch taken.
- lw_EX  in  1  instruction in EX is a load.
- rs1_ID, rs2_ID  in  REG_AW  ID source registers.
- rd_ID  in  REG_AW  ID destination register.
- lop_ID  in  1  ID instruction is a long-latency op writing rd_ID.
- rd_EX  in  REG_AW  EX destination register.
- rs1_EX, rs2_EX  in  REG_AW  EX source registers.
- rd_MEM, rd_WB  in  REG_AW  MEM/WB destination registers.
- reg_wr_MEM, reg_wr_WB  in  1  MEM/WB write enables.
- stall  out  1  freeze PC and IF/ID.
- flush_ID  out  1  kill IF/ID.
- flush_EX  out  1  bubble into ID/EX.
- sel_A, sel_B  out  2  forward select: 00 reg, 01 MEM, 10 WB.
- lop_busy  out  1  scoreboard entry valid.
- lop_done  out  1  one-cycle pulse; long-op result writes back this cycle.
- lop_rd  out  REG_AW  destination of the outstanding long op.

Behaviour:
- Forwarding (combinational):
  - sel_A = 01 if rs1_EX==rd_MEM && reg_wr_MEM && rs1_EX!=0.
  - else 10 if rs1_EX==rd_WB && reg_wr_WB && rs1_EX!=0.
  - else 00. sel_B is identical using rs2_EX. MEM has priority over WB.
- load_stall = lw_EX && rd_EX!=0 && (rs1_ID==rd_EX || rs2_ID==rd_EX).
- sb_stall = lop_busy && lop_rd!=0 && (rs1_ID==lop_rd || rs2_ID==lop_rd || rd_ID==lop_rd). This covers RAW and WAW.
- struct_stall = lop_ID && lop_busy.
- stall = load_stall || sb_stall || struct_stall.
- flush_EX = stall || sel_PC[1].
- flush_ID = |sel_PC.
- Issue: issue = lop_ID && !stall && !sel_PC[1]. A long op killed by a taken branch/JR never enters the scoreboard.
- Scoreboard states:
  - IDLE: lop_busy=0.
  - On issue at edge T: go to BUSY, capture lop_rd<=rd_ID, load cnt<=LOP_LATENCY-1.
  - BUSY: decrement cnt each cycle. When cnt==0, lop_done=1 for that cycle, which is cycle T+LOP_LATENCY. Return to IDLE at the next edge.
  - lop_busy is high through the done cycle inclusive, so dependent or structural stalls also hold during the done cycle. The earliest back-to-back issue is cycle T+LOP_LATENCY+1.
- cnt width is $clog2(LOP_LATENCY+1); no wrap, since cnt never decrements below 0.
- lop_rd==0 issue: the op is tracked (busy, done pulse) but never causes a register-dependency stall.
- Asynchronous reset:
  - lop_busy=0, lop_done=0, lop_rd=0, cnt=0.
  - The combinational outputs follow their inputs; stall depends only on load_stall while reset is held.
  - Reset during BUSY abandons the op with no done pulse.
- Simultaneous events:
  - stall and taken branch in the same cycle: both flushes assert; issue is suppressed.
  - A branch does not cancel an already-issued op.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W].
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with flush_ID=1.
  - Both saturate at all-ones and reset to 0 asynchronously.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - PC_NEXT/PC_JUMP/PC_JR/PC_BRANCH constants.
  - FWD_REG/FWD_MEM/FWD_WB 2-bit constants.
  - Scoreboard state enum (IDLE, BUSY).
- One sub-module, lop_tracker: counter, busy/done and lop_rd capture. The top level holds forwarding and stall/flush logic.

Test Plan:
- Forwarding: rs1_EX=5, rd_MEM=5, reg_wr_MEM=1, rd_WB=5, reg_wr_WB=1 -> sel_A=01. Set rs1_EX=0 -> sel_A=00.
- Load-use: lw_EX=1, rd_EX=8, rs2_ID=8 -> stall=1, flush_EX=1, flush_ID=0. Set rd_EX=0 -> stall=0.
- Long op with LOP_LATENCY=4: issue at cycle 0 with rd_ID=9, then present rs1_ID=9 in ID -> stall high cycles 1-4, lop_done=1 at cycle 4 only, stall=0 at cycle 5.
- Structural/WAW: second lop_ID while busy -> stall. Non-long op with rd_ID==lop_rd -> stall. Unrelated register ops -> no stall.
- Branch kill: lop_ID=1 with sel_PC=11 -> flush_ID=1, flush_EX=1, lop_busy stays 0.
- Reset: drop rst_n mid-BUSY (cycle 2) -> lop_busy=0 immediately, no lop_done. With HAZARD_PERF_CNT_EN, counters read 0.
